fu_issue_arbiter: RTL
=====================

# fu_issue_arbiter

Shares one functional unit between the issue ports of several reservation-station banks. It selects the oldest issuable micro-op by ROB age and registers it into a single output stage toward the FU. It also holds off all banks while a non-pipelined long-latency operation (divide, CSR, etc.) is outstanding. The block sits between the RS issue outputs and the FU input latch; flush clears it together with the RS.

## Interface
Parameters:
- REQ_NUM, 2, number of requesting RS banks (≥1).
- OPTION_CODE, OptionCodeSt, FU option-code type forwarded untouched.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush, synchronous.
- req_valid_i  in  REQ_NUM  per-bank issue valid.
- req_ready_o  out  REQ_NUM  per-bank grant/accept; one-hot or zero.
- req_base_i  in  REQ_NUM×IssueBaseSt  issue payload.
- req_oc_i  in  REQ_NUM×OPTION_CODE  option code.
- req_pos_bit_i  in  REQ_NUM  ROB wrap (position) bit.
- req_rob_idx_i  in  REQ_NUM×$clog2(`ROB_DEPTH)  ROB index.
- req_long_i  in  REQ_NUM  op is non-pipelined; FU completes it with fu_done_i.
- fu_valid_o  out  1  output stage valid.
- fu_ready_i  in  1  FU accepts the output stage.
- fu_base_o  out  IssueBaseSt  registered payload.
- fu_oc_o  out  OPTION_CODE  registered option code.
- fu_done_i  in  1  FU finished the outstanding long op.
- busy_o  out  1  state is WAIT_DONE.

## Operation
- Age compare, a older than b: equal pos bits → rob_idx_a < rob_idx_b; different pos bits → rob_idx_a > rob_idx_b. Exact age tie → lowest bank index wins.
- Grant: among the valid requests, pick the oldest. Assert req_ready_o for that bank only when the stage can accept.
- Stage can accept: (state IDLE) and (!fu_valid_o or fu_ready_i) and !flush_i.
- Accept (req_valid_i&req_ready_o): at the next edge the stage loads base, oc and the long flag, and fu_valid_o=1.
- FSM states:
  - IDLE: normal operation.
  - WAIT_DONE: entered when a stage entry with long=1 handshakes with the FU (fu_valid_o&fu_ready_i).
    - req_ready_o=0 throughout.
    - Leaves to IDLE on the edge after fu_done_i=1; grants may resume that next cycle.
- fu_done_i is ignored in IDLE.
- Stage drain without refill (handshake, no new accept) → fu_valid_o=0 next cycle.
- A long op in the stage does not stop the stage from being refilled in the same cycle it handshakes; the FSM moves to WAIT_DONE regardless. The refilled op waits in the stage.
- Flush:
  - Next edge: stage invalid, FSM IDLE.
  - During the flush cycle: req_ready_o=0, and any handshake that cycle is discarded.

## Timing
- Reset values: fu_valid_o=0, fu_base_o=0, fu_oc_o=0, busy_o=0, FSM=IDLE.
- req_ready_o is combinational from the inputs and state; it is 0 while in reset.
- Latency: accept at cycle t → fu_valid_o at t+1. With fu_ready_i held high, throughput is 1 op/cycle for pipelined ops.
- Stall: fu_valid_o=1 and fu_ready_i=0 → payload stable, req_ready_o=0.
- Long op: handshake at t → busy_o=1 from t+1. fu_done_i at d → busy_o=0 at d+1, first new grant at d+1.
- fu_done_i in the same cycle as entering WAIT_DONE is ignored (done is only sampled in WAIT_DONE).
- Reset asserted mid-operation: everything returns to reset values asynchronously, and the outstanding long op is abandoned.

## Structure
- Age compare goes in Scheduler.svh as the shared function rob_older(pos_a, idx_a, pos_b, idx_b); the RS select logic reuses it.
- FSM state enum FuArbStateE {IDLE, WAIT_DONE} goes in Scheduler.svh.
- One sub-module: fu_age_select, a combinational oldest-of-N selector producing a one-hot grant plus a valid. The top level holds the stage register and the FSM.
- Estimated size: ~180 lines.

## Test plan
- Two banks valid; bank0 pos=0 idx=5, bank1 pos=0 idx=3 → req_ready_o=2'b10; next cycle fu_base_o = bank1 payload.
- Wrap: bank0 pos=1 idx=1, bank1 pos=0 idx=30 → bank1 granted; equal age → bank0 granted.
- fu_ready_i=0 for 3 cycles with fu_valid_o=1 → payload constant, req_ready_o=0. Raise fu_ready_i → new grant in the same cycle, refill next edge.
- Long op handshake at cycle 10, fu_done_i at cycle 15 → busy_o=1 on cycles 11–15, req_ready_o=0 on cycles 11–15, grant on cycle 16.
- flush_i during WAIT_DONE with the stage valid → next cycle fu_valid_o=0, busy_o=0, grants resume.
- rst_n pulsed low mid-stall → fu_valid_o=0 immediately; fu_done_i after release is ignored.

Source files
------------

// File: rtl/fu_issue_arbiter_pkg.sv
// Shared scheduler types and the ROB age compare used by the FU issue arbiter
// and the RS select logic.
package fu_issue_arbiter_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [7:0]  tag;
    logic [4:0]  dst;
    logic [31:0] imm;
  } IssueBaseSt;

  typedef struct packed {
    logic [3:0] op;
    logic       sgn;
  } OptionCodeSt;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_DONE
  } FuArbStateE;

  // Entries on opposite sides of the ROB wrap compare in reverse index order.
  function automatic logic rob_older(input logic                 pos_a,
                                     input logic [ROB_IDX_W-1:0] idx_a,
                                     input logic                 pos_b,
                                     input logic [ROB_IDX_W-1:0] idx_b);
    if (pos_a == pos_b) return (idx_a < idx_b);
    else                return (idx_a > idx_b);
  endfunction

endpackage

// File: rtl/fu_issue_arbiter_age_select.sv
// Combinational oldest-of-N selector: one-hot grant of the oldest valid
// request by ROB age, lowest index winning an exact tie.
module fu_age_select
  import fu_issue_arbiter_pkg::*;
#(
  parameter int REQ_NUM = 2
) (
  input  logic [REQ_NUM-1:0]   valid,
  input  logic [REQ_NUM-1:0]   pos_bit,
  input  logic [ROB_IDX_W-1:0] rob_idx [REQ_NUM],
  output logic [REQ_NUM-1:0]   grant,
  output logic                 any_valid
);

  localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [IW-1:0] best;
  logic          found;

  // Strictly-older replaces the incumbent, so ties keep the lower bank.
  always_comb begin
    grant = '0;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (valid[i] &&
          (!found || rob_older(pos_bit[i], rob_idx[i], pos_bit[best], rob_idx[best]))) begin
        found = 1'b1;
        best  = i[IW-1:0];
      end
    end
    if (found) grant[best] = 1'b1;
    any_valid = found;
  end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Oldest-first issue arbiter in front of one shared FU: single output stage
// plus a hold-off FSM for non-pipelined long-latency operations.
module fu_issue_arbiter
  import fu_issue_arbiter_pkg::*;
#(
  parameter int  REQ_NUM     = 2,
  parameter type OPTION_CODE = OptionCodeSt
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [REQ_NUM-1:0]   req_valid_i,
  output logic [REQ_NUM-1:0]   req_ready_o,
  input  IssueBaseSt           req_base_i    [REQ_NUM],
  input  OPTION_CODE           req_oc_i      [REQ_NUM],
  input  logic [REQ_NUM-1:0]   req_pos_bit_i,
  input  logic [ROB_IDX_W-1:0] req_rob_idx_i [REQ_NUM],
  input  logic [REQ_NUM-1:0]   req_long_i,
  output logic                 fu_valid_o,
  input  logic                 fu_ready_i,
  output IssueBaseSt           fu_base_o,
  output OPTION_CODE           fu_oc_o,
  input  logic                 fu_done_i,
  output logic                 busy_o
);

  FuArbStateE   state;
  logic         vld_p0;
  logic         long_p0;
  IssueBaseSt   base_p0;
  OPTION_CODE   oc_p0;

  logic [REQ_NUM-1:0] grant;
  logic               any_valid;
  logic               can_accept;
  logic               accept;
  logic               fu_hs;
  IssueBaseSt         sel_base;
  OPTION_CODE         sel_oc;
  logic               sel_long;

  fu_age_select #(
    .REQ_NUM (REQ_NUM)
  ) u_age_select (
    .valid     (req_valid_i),
    .pos_bit   (req_pos_bit_i),
    .rob_idx   (req_rob_idx_i),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign fu_hs      = vld_p0 && fu_ready_i;
  assign can_accept = (state == IDLE) && (!vld_p0 || fu_ready_i) && !flush_i;
  assign req_ready_o = (can_accept && rst_n) ? grant : '0;
  assign accept     = any_valid && can_accept;

  always_comb begin
    sel_base = '0;
    sel_oc   = '0;
    sel_long = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) begin
        sel_base = req_base_i[i];
        sel_oc   = req_oc_i[i];
        sel_long = req_long_i[i];
      end
    end
  end

  // Stage p0: output register toward the FU, and the long-op hold-off FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld_p0  <= 1'b0;
      long_p0 <= 1'b0;
      base_p0 <= '0;
      oc_p0   <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      vld_p0  <= 1'b0;
      long_p0 <= 1'b0;
    end else begin
      if (accept) begin
        vld_p0  <= 1'b1;
        long_p0 <= sel_long;
        base_p0 <= sel_base;
        oc_p0   <= sel_oc;
      end else if (fu_hs) begin
        vld_p0  <= 1'b0;
        long_p0 <= 1'b0;
      end
      // A refill in the same cycle does not cancel the hold-off.
      case (state)
        IDLE:      if (fu_hs && long_p0) state <= WAIT_DONE;
        WAIT_DONE: if (fu_done_i)        state <= IDLE;
        default:                         state <= IDLE;
      endcase
    end
  end

  assign fu_valid_o = vld_p0;
  assign fu_base_o  = base_p0;
  assign fu_oc_o    = oc_p0;
  assign busy_o     = (state == WAIT_DONE);

endmodule
